regfile_dump: RTL and testbench

// - Read-side debug engine for the CPU register file: on a start pulse, walks the debug read port
//   (address out, 32-bit word in) across registers FIRST_REG..LAST_REG and serialises each word
//   as a byte stream over a valid/ready handshake.
// - The byte stream feeds the UART TX or display path. Never writes the register file.

---
 rtl/cpu_dbg_pkg.sv | 21 ++
 rtl/hex_nibble_ascii.sv | 18 +
 rtl/regfile_dump.sv | 180 ++++++++++++++++++
 tb/tb_regfile_dump.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug read-side helpers.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        SEND,
        FIN
    } dump_state_e;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int unsigned BYTES_HEX = 9;
    localparam int unsigned BYTES_RAW = 4;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Converts one nibble to its lowercase ASCII hex character.
module hex_nibble_ascii
    import cpu_dbg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Digits map onto '0'..'9', values 10..15 onto 'a'..'f'.
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_0 + {4'd0, nibble_i};
        end else begin
            ascii_o = ASCII_A_LC + {4'd0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Walks the register-file debug read port over FIRST_REG..LAST_REG and
// streams each word as hex text or raw bytes over a valid/ready handshake.
module regfile_dump
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter bit          HEX_ASCII = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [31:0]           dbg_rdata,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] FIRST_ADDR = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_ADDR  = REG_ADDR_W'(LAST_REG);
    localparam logic [3:0]            LAST_IDX   = HEX_ASCII ? 4'(BYTES_HEX - 1)
                                                             : 4'(BYTES_RAW - 1);

    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("regfile_dump: FIRST_REG/LAST_REG out of range");
    end

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]           word_q,  word_d;
    logic [3:0]            idx_q,   idx_d;
    logic [7:0]            data_q,  data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic [31:0] sel_word;
    logic [3:0]  sel_idx;
    logic [3:0]  nibble;
    logic [7:0]  nibble_ascii;
    logic [7:0]  next_byte;

    // Byte 0 is taken straight from the read port while latching; later bytes come from the latched word.
    always_comb begin
        sel_word = (state_q == LATCH) ? dbg_rdata : word_q;
        sel_idx  = (state_q == LATCH) ? 4'd0 : idx_q + 4'd1;
    end

    // Nibble select, most significant nibble first.
    always_comb begin
        nibble = '0;
        case (sel_idx[2:0])
            3'd0:    nibble = sel_word[31:28];
            3'd1:    nibble = sel_word[27:24];
            3'd2:    nibble = sel_word[23:20];
            3'd3:    nibble = sel_word[19:16];
            3'd4:    nibble = sel_word[15:12];
            3'd5:    nibble = sel_word[11:8];
            3'd6:    nibble = sel_word[7:4];
            default: nibble = sel_word[3:0];
        endcase
    end

    hex_nibble_ascii u_hex_nibble_ascii (
        .nibble_i (nibble),
        .ascii_o  (nibble_ascii)
    );

    // Output byte mux: hex characters plus line feed, or raw bytes MSB first.
    always_comb begin
        next_byte = '0;
        if (HEX_ASCII) begin
            next_byte = (sel_idx == 4'd8) ? ASCII_LF : nibble_ascii;
        end else begin
            case (sel_idx[1:0])
                2'd0:    next_byte = sel_word[31:24];
                2'd1:    next_byte = sel_word[23:16];
                2'd2:    next_byte = sel_word[15:8];
                default: next_byte = sel_word[7:0];
            endcase
        end
    end

    // Dump sequencer next-state logic; abort overrides every active state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            addr_d  = FIRST_ADDR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = ADDR;
                        addr_d  = FIRST_ADDR;
                        busy_d  = 1'b1;
                    end
                end
                ADDR: begin
                    state_d = LATCH;
                end
                LATCH: begin
                    word_d  = dbg_rdata;
                    idx_d   = '0;
                    data_d  = next_byte;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
                SEND: begin
                    if (valid_q && out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            valid_d = 1'b0;
                            if (addr_q == LAST_ADDR) begin
                                state_d = FIN;
                            end else begin
                                addr_d  = addr_q + 5'd1;
                                state_d = ADDR;
                            end
                        end else begin
                            idx_d  = idx_q + 4'd1;
                            data_d = next_byte;
                        end
                    end
                end
                FIN: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= FIRST_ADDR;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dbg_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: three instances (hex single register, raw 2..3, default hex 0..31).
module tb_regfile_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] rf [32];

    logic       st  [3];
    logic       ab  [3];
    logic       rdy [3];
    logic       rn  [3];
    logic [4:0] ad  [3];
    logic [31:0] rd [3];
    logic [7:0] od  [3];
    logic       ov  [3];
    logic       bsy [3];
    logic       dn  [3];

    assign rd[0] = rf[ad[0]];
    assign rd[1] = rf[ad[1]];
    assign rd[2] = rf[ad[2]];

    regfile_dump #(.FIRST_REG(1), .LAST_REG(1), .HEX_ASCII(1'b1)) u_hex (
        .clk(clk), .rst_n(rn[0]), .start(st[0]), .abort(ab[0]), .dbg_addr(ad[0]),
        .dbg_rdata(rd[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .busy(bsy[0]), .done(dn[0]));

    regfile_dump #(.FIRST_REG(2), .LAST_REG(3), .HEX_ASCII(1'b0)) u_raw (
        .clk(clk), .rst_n(rn[1]), .start(st[1]), .abort(ab[1]), .dbg_addr(ad[1]),
        .dbg_rdata(rd[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .busy(bsy[1]), .done(dn[1]));

    regfile_dump u_full (
        .clk(clk), .rst_n(rn[2]), .start(st[2]), .abort(ab[2]), .dbg_addr(ad[2]),
        .dbg_rdata(rd[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy[2]),
        .busy(bsy[2]), .done(dn[2]));

    int checks = 0;
    int errors = 0;

    logic [7:0] got      [$];
    logic [4:0] got_addr [$];
    int         got_cyc  [$];
    logic [7:0] exp_q    [$];
    int         done_cnt [3];
    bit         hold     [3];
    logic [7:0] hold_data[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Observer: records accepted bytes, done pulses and checks stall stability.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (hold[k] && ov[k]) begin
                checks++;
                if (od[k] !== hold_data[k]) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: got %02h expected %02h", k, od[k], hold_data[k]);
                end
            end
            hold[k]      = ov[k] && !rdy[k];
            hold_data[k] = od[k];
            if (ov[k] && rdy[k]) begin
                got.push_back(od[k]);
                got_addr.push_back(ad[k]);
                got_cyc.push_back(cyc);
            end
            if (dn[k]) done_cnt[k]++;
        end
    end

    // Reference stream computed from the register contents.
    task automatic build_exp(input int first, input int last, input bit hex);
        string s;
        exp_q.delete();
        for (int r = first; r <= last; r++) begin
            if (hex) begin
                s = $sformatf("%08h", rf[r]);
                for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
                exp_q.push_back(8'h0A);
            end else begin
                for (int i = 0; i < 4; i++) exp_q.push_back(8'((rf[r] >> (24 - 8 * i)) & 32'hFF));
            end
        end
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1 st[k] = 1'b1;
        @(posedge clk); #1 st[k] = 1'b0;
    endtask

    // Full dump with bounded wait for done; optional random ready, rf poke and extra start.
    task automatic run_dump(input int k, input bit rnd, input int poke, input int restart_at);
        int  d0;
        bit  finished;
        d0 = done_cnt[k];
        got.delete(); got_addr.delete(); got_cyc.delete();
        rdy[k] = 1'b1;
        pulse_start(k);
        chk("busy_after_start", 64'(bsy[k]), 64'd1);
        finished = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            rdy[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (n == poke) rf[1] = ~rf[1];
            st[k] = (n == restart_at);
            @(posedge clk); #1;
            if (done_cnt[k] != d0) begin
                finished = 1'b1;
                break;
            end
        end
        st[k] = 1'b0;
        chk("dump_finished", 64'(finished), 64'd1);
        chk("busy_after_done", 64'(bsy[k]), 64'd0);
        rdy[k] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("single_done", 64'(done_cnt[k] - d0), 64'd1);
    endtask

    typedef struct {
        logic [31:0] word;
        string       text;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int d0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; ab[k] = 1'b0; rdy[k] = 1'b0; rn[k] = 1'b0;
            done_cnt[k] = 0; hold[k] = 1'b0; hold_data[k] = '0;
        end
        for (int r = 0; r < 32; r++) rf[r] = $urandom;

        tbl[0] = '{32'h12AB34CD, "12ab34cd"};
        tbl[1] = '{32'h00000000, "00000000"};
        tbl[2] = '{32'hFFFFFFFF, "ffffffff"};
        tbl[3] = '{32'h9A0F5E6B, "9a0f5e6b"};

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr0", 64'(ad[0]), 64'd1);
        chk("rst_addr1", 64'(ad[1]), 64'd2);
        chk("rst_addr2", 64'(ad[2]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_data%0d", k), 64'(od[k]), 64'd0);
            chk($sformatf("rst_valid%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_busy%0d", k), 64'(bsy[k]), 64'd0);
            chk($sformatf("rst_done%0d", k), 64'(dn[k]), 64'd0);
        end
        for (int k = 0; k < 3; k++) begin rn[k] = 1'b1; rdy[k] = 1'b1; end
        repeat (6) @(posedge clk);
        #1;
        chk("idle_no_bytes", 64'(got.size()), 64'd0);
        chk("idle_valid", 64'(ov[0] | ov[1] | ov[2]), 64'd0);

        // start together with abort in IDLE is ignored.
        @(posedge clk); #1 st[0] = 1'b1; ab[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0; ab[0] = 1'b0;
        chk("start_abort_idle_busy", 64'(bsy[0]), 64'd0);
        repeat (4) @(posedge clk);
        #1 chk("start_abort_idle_bytes", 64'(got.size()), 64'd0);

        // Table-driven hex vectors with continuous ready.
        for (int v = 0; v < 4; v++) begin
            rf[1] = tbl[v].word;
            run_dump(0, 1'b0, -1, -1);
            chk($sformatf("tbl%0d_len", v), 64'(got.size()), 64'd9);
            for (int i = 0; i < 9 && i < got.size(); i++)
                chk($sformatf("tbl%0d_b%0d", v, i), 64'(got[i]),
                    64'((i == 8) ? 8'h0A : 8'(tbl[v].text[i])));
            if (got.size() == 9)
                chk($sformatf("tbl%0d_b2b", v), 64'(got_cyc[8] - got_cyc[0]), 64'd8);
        end

        // Backpressure with a register-file write after the word was latched.
        rf[1] = 32'h12AB34CD;
        build_exp(1, 1, 1'b1);
        run_dump(0, 1'b1, 3, -1);
        cmp_stream("hex_bp");

        // Raw, two registers, with register-address check.
        rf[2] = 32'hDEADBEEF;
        rf[3] = 32'h00000001;
        build_exp(2, 3, 1'b0);
        run_dump(1, 1'b0, -1, -1);
        cmp_stream("raw_known");
        for (int i = 0; i < 8 && i < got_addr.size(); i++)
            chk($sformatf("raw_addr%0d", i), 64'(got_addr[i]), 64'((i < 4) ? 2 : 3));

        // Random raw words under random ready.
        for (int t = 0; t < 4; t++) begin
            rf[2] = $urandom;
            rf[3] = $urandom;
            build_exp(2, 3, 1'b0);
            run_dump(1, 1'b1, -1, -1);
            cmp_stream($sformatf("raw_rand%0d", t));
        end

        // Full default dump with a second start mid-dump.
        build_exp(0, 31, 1'b1);
        run_dump(2, 1'b0, -1, 50);
        cmp_stream("full_restart");
        chk("full_len_288", 64'(got.size()), 64'd288);

        // Abort while byte 4 of r5 is on the output.
        d0 = done_cnt[2];
        got.delete(); got_addr.delete(); got_cyc.delete();
        rdy[2] = 1'b1;
        pulse_start(2);
        for (int n = 0; n < 1000 && got.size() < 49; n++) begin
            @(posedge clk); #1;
        end
        chk("abort_reached", 64'(got.size()), 64'd49);
        ab[2] = 1'b1;
        @(posedge clk); #1 ab[2] = 1'b0;
        chk("abort_valid", 64'(ov[2]), 64'd0);
        chk("abort_busy", 64'(bsy[2]), 64'd0);
        chk("abort_addr", 64'(ad[2]), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_consumed", 64'(got.size()), 64'd50);
        if (got.size() >= 50) chk("abort_last_byte", 64'(got[49]), 64'(exp_q[49]));
        chk("abort_no_done", 64'(done_cnt[2] - d0), 64'd0);

        // Reset pulse during SEND.
        d0 = done_cnt[2];
        got.delete(); got_addr.delete(); got_cyc.delete();
        pulse_start(2);
        for (int n = 0; n < 1000 && !(got.size() >= 12 && ov[2]); n++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_sending", 64'(ov[2]), 64'd1);
        rn[2] = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(ov[2]), 64'd0);
        chk("rst_mid_busy", 64'(bsy[2]), 64'd0);
        chk("rst_mid_addr", 64'(ad[2]), 64'd0);
        @(posedge clk); #1 rn[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("rst_mid_no_done", 64'(done_cnt[2] - d0), 64'd0);

        // Fresh full dump with new random contents and random ready.
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        build_exp(0, 31, 1'b1);
        run_dump(2, 1'b1, -1, -1);
        cmp_stream("full_rand");
        if (got_addr.size() > 0) chk("full_first_addr", 64'(got_addr[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
